sysbus_mem_responder: RTL and testbench
=======================================

// Module: sysbus_mem_responder
//
// PURPOSE
//  Memory-side responder for the Sysbus request/response interface.
//  Models main memory for the fetch front end.
//  Accepts a line request (reqcyc/reqack), waits a fixed latency, then returns one
//  64-byte line as BUS_DATA_WIDTH beats on the response channel (respcyc/respack).
//  Sits at the far end of the bus from top's fetch initiator; used in sim and as the
//  reference memory model for bring-up.
//
// PARAMETERS
//  BUS_DATA_WIDTH  64     data beat width; fixed at 64
//  BUS_TAG_WIDTH   13     tag width; [11:8]=op, [12]=target
//  MEM_WORDS       4096   backing store depth in 64-bit words; power of two
//  LATENCY         4      cycles from reqack to first respcyc; >=1
//  BURST_LEN       8      beats per line (64 B / 8 B)
//  INIT_FILE       ""     hex file loaded with $readmemh at time 0 if non-empty
//
// PORTS
//  clk          in   1               clock
//  reset        in   1               sync, active-high
//  bus_reqcyc   in   1               initiator request valid
//  bus_reqack   out  1               request accepted (1-cycle pulse)
//  bus_req      in   BUS_DATA_WIDTH  byte address (read/write addr); write data beats
//  bus_reqtag   in   BUS_TAG_WIDTH   op/target tag
//  bus_respcyc  out  1               response beat valid
//  bus_respack  in   1               initiator acknowledges response
//  bus_resp     out  BUS_DATA_WIDTH  response data beat
//  bus_resptag  out  BUS_TAG_WIDTH   echo of accepted request tag
//
// BEHAVIOUR
//  - Reset (sync): all outputs 0, FSM->IDLE, counters 0; memory contents untouched.
//    Reset mid-burst aborts immediately: no further beats, next cycle respcyc=0.
//  - FSM: IDLE -> LAT -> RESP0 -> STREAM -> IDLE. WDATA exists only with the macro.
//  - IDLE: on a sampled edge with reqcyc=1, latch line base = bus_req & ~64'h3F and latch bus_reqtag.
//    Next cycle: reqack=1 for exactly one cycle; go to LAT with lat_cnt=LATENCY-1.
//  - reqtag[11:8]==`SYSBUS_READ and reqtag[12]==`SYSBUS_MEMORY -> read path.
//    Any other op/target: ack and return to IDLE with no response.
//    Exception: write, when the macro is enabled (see CONFIGURATION).
//  - LAT: count down. At lat_cnt==0 -> RESP0, with respcyc=1 and bus_resp=beat 0.
//  - RESP0: beat 0 is held, respcyc=1, until respack is sampled 1.
//    Then beats 1..BURST_LEN-1 follow, one per cycle, in STREAM.
//  - STREAM: bus_respack is ignored during these beats.
//    After the last beat's cycle, respcyc=0 and bus_resp=0 -> IDLE.
//  - Beat k data = mem[(base>>3) + k] in ascending order; no critical-word-first.
//    Word index is taken modulo MEM_WORDS (silent wrap, no error).
//  - bus_resptag = latched tag while respcyc=1, else 0.
//  - reqcyc still high in the reqack cycle or during LAT/RESP0/STREAM: ignored, not queued.
//    reqcyc high on the first IDLE cycle after a burst: accepted at once (back-to-back).
//  - respack high before respcyc rises: beat 0 is consumed on the first respcyc cycle.
//  - Total read latency, reqcyc edge to beat 0 visible: 1 + 1 + LATENCY cycles.
//
// CONFIGURATION
//  SYSBUS_MEM_WRITE_EN defined:
//    Write tag (reqtag[11:8]==`SYSBUS_WRITE, memory target) -> WDATA.
//    Each cycle with reqcyc=1 writes bus_req into mem[(base>>3)+k], k=0..BURST_LEN-1,
//    and pulses reqack for that beat.
//    Cycles with reqcyc=0 stall. After beat 7 -> IDLE; no response phase.
//  SYSBUS_MEM_WRITE_EN undefined:
//    Write requests are acked once and dropped; memory is read-only after INIT_FILE.
//
// TESTING
//  1 Reset: reset=1 for 3 cycles with reqcyc=1 -> reqack, respcyc, bus_resp, bus_resptag all 0.
//  2 Read: mem[8..15]=16'h1000+i, LATENCY=4, req 0x47 with read/memory tag.
//    -> reqack pulse at cycle 1; beat 0 = 0x1000 at cycle 6.
//    -> With respack held, beats 0x1001..0x1007 on consecutive cycles.
//  3 Stall: respack held 0 for 5 cycles -> beat 0 stays 0x1000 with respcyc=1.
//    Then respack=1 -> remaining 7 beats back-to-back.
//  4 Wrap: MEM_WORDS=4096, req 0x7FFC0 -> beats read mem[4088..4095].
//    Req 0x8000 -> reads mem[0..7].
//  5 Back-to-back: new reqcyc on the first IDLE cycle after beat 7 -> reqack next cycle.
//    Reset asserted mid-STREAM -> respcyc=0 the following cycle.
//  6 Write (macro on): write tag at 0x40, data 0xA0..0xA7 -> 8 reqack pulses.
//    Read of 0x40 then returns 0xA0..0xA7. Macro off: same read returns the old data.

Source files
------------

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: accepts a line request, waits LATENCY cycles, streams one 64-byte line.
// Define SYSBUS_MEM_WRITE_EN to accept write bursts into the backing store; otherwise memory is read-only.

`ifndef SYSBUS_READ
`define SYSBUS_READ 4'b1101
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 4'b0101
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1'b0
`endif

module sysbus_mem_responder #(
    parameter int    BUS_DATA_WIDTH = 64,
    parameter int    BUS_TAG_WIDTH  = 13,
    parameter int    MEM_WORDS      = 4096,
    parameter int    LATENCY        = 4,
    parameter int    BURST_LEN      = 8,
    parameter string INIT_FILE      = ""
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int CNT_W  = $clog2(LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_LAT,
        S_RESP0,
        S_STREAM
`ifdef SYSBUS_MEM_WRITE_EN
        , S_WDATA
`endif
    } state_t;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   base_q, base_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               reqack_q, reqack_d;

    logic               is_read;
    logic               is_write;
    logic [IDX_W-1:0]   word_idx;
    logic               unused_req;

    // Address bits above the store and within a line never select a word; the index wraps silently.
    assign unused_req = ^{bus_req[BUS_DATA_WIDTH-1:IDX_W+3], bus_req[BEAT_W+2:0]};
    assign word_idx   = base_q + IDX_W'(beat_q);
    assign is_read    = (tag_q[11:8] == `SYSBUS_READ)  && (tag_q[12] == `SYSBUS_MEMORY);
    assign is_write   = (tag_q[11:8] == `SYSBUS_WRITE) && (tag_q[12] == `SYSBUS_MEMORY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            tag_q    <= '0;
            lat_q    <= '0;
            beat_q   <= '0;
            reqack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            tag_q    <= tag_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            reqack_q <= reqack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        tag_d    = tag_q;
        lat_d    = lat_q;
        beat_d   = beat_q;
        reqack_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The last write-beat ack lands in IDLE; that cycle must not start a new request.
                if (bus_reqcyc && !reqack_q) begin
                    base_d   = {bus_req[IDX_W+2:BEAT_W+3], BEAT_W'(0)};
                    tag_d    = bus_reqtag;
                    reqack_d = 1'b1;
                    beat_d   = '0;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                if (is_read) begin
                    lat_d   = CNT_W'(LATENCY - 1);
                    state_d = S_LAT;
`ifdef SYSBUS_MEM_WRITE_EN
                end else if (is_write) begin
                    beat_d  = '0;
                    state_d = S_WDATA;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAT: begin
                if (lat_q == '0) begin
                    beat_d  = '0;
                    state_d = S_RESP0;
                end else begin
                    lat_d = lat_q - CNT_W'(1);
                end
            end
            S_RESP0: begin
                if (bus_respack) begin
                    beat_d  = BEAT_W'(1);
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                    beat_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
`ifdef SYSBUS_MEM_WRITE_EN
            S_WDATA: begin
                if (bus_reqcyc) begin
                    reqack_d = 1'b1;
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SYSBUS_MEM_WRITE_EN
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_WDATA && bus_reqcyc) begin
            mem[word_idx] <= bus_req;
        end
    end
`else
    logic unused_write;
    assign unused_write = is_write;
`endif

    assign bus_reqack  = reqack_q;
    assign bus_respcyc = (state_q == S_RESP0) || (state_q == S_STREAM);
    assign bus_resp    = bus_respcyc ? mem[word_idx] : '0;
    assign bus_resptag = bus_respcyc ? tag_q : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: reset, read latency, stall, wrap, back-to-back, abort, write.
module tb_sysbus_mem_responder;

    localparam logic [12:0] READ_TAG    = 13'h0D00;
    localparam logic [12:0] WRITE_TAG   = 13'h0500;
    localparam logic [12:0] IO_READ_TAG = 13'h1D00;

    logic        clk;
    logic        reset;
    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;

    int checks = 0;
    int errors = 0;

    sysbus_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock edge; returns mid-cycle so outputs are sampled away from the edge
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single comparison point, counted and reported on mismatch
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full read transaction from a fresh request; optionally stalls beat 0 or acks early
    task automatic readLine(input string name, input logic [63:0] addr, input logic [63:0] firstWord,
                            input int stall, input bit earlyAck);
        bus_reqcyc  = 1'b1;
        bus_req     = addr;
        bus_reqtag  = READ_TAG;
        bus_respack = earlyAck;
        applyStimulus();
        checkOutput({name, " reqack cycle1"}, 64'(bus_reqack), 64'd1);
        applyStimulus();
        bus_reqcyc = 1'b0;
        checkOutput({name, " reqack cycle2"}, 64'(bus_reqack), 64'd0);
        for (int c = 2; c < 6; c++) begin
            checkOutput({name, " respcyc latency"}, 64'(bus_respcyc), 64'd0);
            applyStimulus();
        end
        checkOutput({name, " beat0 respcyc"}, 64'(bus_respcyc), 64'd1);
        checkOutput({name, " beat0 data"}, bus_resp, firstWord);
        checkOutput({name, " beat0 tag"}, 64'(bus_resptag), 64'(READ_TAG));
        for (int s = 0; s < stall; s++) begin
            applyStimulus();
            checkOutput({name, " stall respcyc"}, 64'(bus_respcyc), 64'd1);
            checkOutput({name, " stall data"}, bus_resp, firstWord);
        end
        bus_respack = 1'b1;
        applyStimulus();
        bus_respack = 1'b0;
        for (int k = 1; k < 8; k++) begin
            checkOutput({name, " stream respcyc"}, 64'(bus_respcyc), 64'd1);
            checkOutput({name, " stream data"}, bus_resp, firstWord + 64'(k));
            applyStimulus();
        end
        checkOutput({name, " end respcyc"}, 64'(bus_respcyc), 64'd0);
        checkOutput({name, " end data"}, bus_resp, 64'd0);
        checkOutput({name, " end tag"}, 64'(bus_resptag), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        bus_reqcyc  = 1'b1;
        bus_req     = 64'h47;
        bus_reqtag  = READ_TAG;
        bus_respack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dut.mem[8 + i]    = 64'h1000 + 64'(i);
            dut.mem[4088 + i] = 64'h2000 + 64'(i);
            dut.mem[i]        = 64'h3000 + 64'(i);
        end

        // Reset held with a pending request: everything stays quiet
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput("reset reqack", 64'(bus_reqack), 64'd0);
            checkOutput("reset respcyc", 64'(bus_respcyc), 64'd0);
            checkOutput("reset resp", bus_resp, 64'd0);
            checkOutput("reset resptag", 64'(bus_resptag), 64'd0);
        end
        reset      = 1'b0;
        bus_reqcyc = 1'b0;
        applyStimulus();

        readLine("read 0x47", 64'h47, 64'h1000, 0, 1'b0);
        applyStimulus();
        readLine("stall", 64'h40, 64'h1000, 5, 1'b0);
        applyStimulus();
        readLine("wrap top", 64'h7FFC0, 64'h2000, 0, 1'b1);
        applyStimulus();
        readLine("wrap 0x8000", 64'h8000, 64'h3000, 0, 1'b0);
        // Back-to-back: request on the very first IDLE cycle after beat 7
        readLine("back2back", 64'h7FFF8, 64'h2000, 1, 1'b0);

        // Non-memory target is acked but never answered
        bus_reqcyc = 1'b1;
        bus_req    = 64'h40;
        bus_reqtag = IO_READ_TAG;
        applyStimulus();
        bus_reqcyc = 1'b0;
        checkOutput("io reqack", 64'(bus_reqack), 64'd1);
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            checkOutput("io no respcyc", 64'(bus_respcyc), 64'd0);
        end

        // Reset mid-STREAM aborts the burst on the next cycle
        bus_reqcyc  = 1'b1;
        bus_req     = 64'h40;
        bus_reqtag  = READ_TAG;
        bus_respack = 1'b1;
        applyStimulus();
        bus_reqcyc = 1'b0;
        repeat (7) applyStimulus();
        checkOutput("abort pre stream", 64'(bus_respcyc), 64'd1);
        checkOutput("abort pre data", bus_resp, 64'h1002);
        reset = 1'b1;
        applyStimulus();
        reset       = 1'b0;
        bus_respack = 1'b0;
        checkOutput("abort respcyc", 64'(bus_respcyc), 64'd0);
        checkOutput("abort resp", bus_resp, 64'd0);
        applyStimulus();
        checkOutput("abort stays idle", 64'(bus_respcyc), 64'd0);

        // Write burst to 0x40, then read it back
        bus_reqcyc = 1'b1;
        bus_req    = 64'h40;
        bus_reqtag = WRITE_TAG;
        applyStimulus();
        bus_reqcyc = 1'b0;
        checkOutput("write addr reqack", 64'(bus_reqack), 64'd1);
        applyStimulus();
        checkOutput("write reqack drop", 64'(bus_reqack), 64'd0);
`ifdef SYSBUS_MEM_WRITE_EN
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                bus_reqcyc = 1'b0;
                applyStimulus();
                checkOutput("write stall reqack", 64'(bus_reqack), 64'd0);
            end
            bus_reqcyc = 1'b1;
            bus_req    = 64'hA0 + 64'(k);
            applyStimulus();
            checkOutput("write beat reqack", 64'(bus_reqack), 64'd1);
        end
        bus_reqcyc = 1'b0;
        applyStimulus();
        checkOutput("write done reqack", 64'(bus_reqack), 64'd0);
        checkOutput("write no respcyc", 64'(bus_respcyc), 64'd0);
        readLine("readback", 64'h40, 64'hA0, 0, 1'b0);
`else
        checkOutput("write no respcyc", 64'(bus_respcyc), 64'd0);
        applyStimulus();
        readLine("readback ro", 64'h40, 64'h1000, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
